// File: rtl/peripheral_operand_pkg.sv
// rtl/peripheral_operand_pkg.sv - shared types and sizing helpers for the operand loader
package peripheral_operand_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} loader_state_t;

  // Number of bytes that make up one operand/result word.
  function automatic int bytes_per_op(input int op_w, input int byte_w);
    return op_w / byte_w;
  endfunction

  // Index width that never collapses to zero bits when only one slot exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peripheral_edge_detect.sv
// rtl/peripheral_edge_detect.sv - optional 2-flop synchroniser plus rising-edge strobe (PERIPHERAL_OPERAND_LOADER_SYNC_EN)
module peripheral_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic level;
  logic sample_q;
  logic prev_q;

`ifdef PERIPHERAL_OPERAND_LOADER_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser for an asynchronous button level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], sig_i};
  end

  assign level = sync_q[1];
`else
  assign level = sig_i;
`endif

  // Sample the level and remember the previous sample for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= level;
      prev_q   <= sample_q;
    end
  end

  // High for the one cycle after a 0->1 transition was sampled; it acts on the next edge.
  assign rise_o = sample_q & ~prev_q;

endmodule

// File: rtl/peripheral_operand_loader.sv
// rtl/peripheral_operand_loader.sv - byte-serial operand entry and result readback (PERIPHERAL_OPERAND_LOADER_SYNC_EN)
module peripheral_operand_loader
  import peripheral_operand_pkg::*;
#(
  parameter  int BYTE_W  = 8,
  parameter  int OP_W    = 32,
  parameter  int NUM_OPS = 2,
  localparam int BYTES   = bytes_per_op(OP_W, BYTE_W),
  localparam int OPI_W   = idx_width(NUM_OPS),
  localparam int BI_W    = idx_width(BYTES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BYTE_W-1:0]         inputdata,
  input  logic                      enterpulse,
  input  logic                      loaddata,
  input  logic                      clear,
  input  logic [OP_W-1:0]           dataR,
  output logic [NUM_OPS*OP_W-1:0]   operands,
  output logic                      operands_valid,
  output logic                      load_done,
  output logic [BYTE_W-1:0]         dataoutput,
  output logic [OPI_W-1:0]          op_idx,
  output logic [BI_W-1:0]           byte_idx
);

  loader_state_t             state_q, state_d;
  logic [OPI_W-1:0]          op_idx_q, op_idx_d;
  logic [BI_W-1:0]           byte_idx_q, byte_idx_d;
  logic [BI_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [NUM_OPS*OP_W-1:0]   operands_q, operands_d;
  logic [BYTE_W-1:0]         dout_q, dout_d;
  logic                      load_done_q, load_done_d;

  logic enter_ev;
  logic mode_load;
  logic act_load;
  logic act_rd;
  logic last_byte;
  logic last_op;
  logic completing;

  peripheral_edge_detect u_enter_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (enterpulse),
    .rise_o (enter_ev)
  );

`ifdef PERIPHERAL_OPERAND_LOADER_SYNC_EN
  logic [1:0] mode_sync_q;

  // Mode select goes through the same synchroniser depth as the enter button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_sync_q <= 2'b00;
    else       mode_sync_q <= {mode_sync_q[0], loaddata};
  end

  assign mode_load = mode_sync_q[1];
`else
  assign mode_load = loaddata;
`endif

  // Clear outranks a coincident enter event, which is simply dropped.
  assign act_load   = enter_ev & mode_load  & ~clear;
  assign act_rd     = enter_ev & ~mode_load & ~clear;
  assign last_byte  = (byte_idx_q == BI_W'(BYTES - 1));
  assign last_op    = (op_idx_q == OPI_W'(NUM_OPS - 1));
  assign completing = act_load & last_byte & last_op;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: any load either completes the set or leaves a partial one.
  always_comb begin
    state_d = state_q;
    if (clear)         state_d = ST_IDLE;
    else if (act_load) state_d = completing ? ST_READY : ST_LOAD;
  end

  // Output decode from state and datapath registers.
  always_comb begin
    operands_valid = (state_q == ST_READY);
    load_done      = load_done_q;
    operands       = operands_q;
    dataoutput     = dout_q;
    op_idx         = op_idx_q;
    byte_idx       = byte_idx_q;
  end

  // Datapath next values: load pointers, read pointer, operand bytes and display byte.
  always_comb begin
    int wr_base;
    int rd_base;
    op_idx_d    = op_idx_q;
    byte_idx_d  = byte_idx_q;
    rd_ptr_d    = rd_ptr_q;
    operands_d  = operands_q;
    dout_d      = dout_q;
    load_done_d = completing;
    wr_base     = int'(op_idx_q) * OP_W + int'(byte_idx_q) * BYTE_W;
    rd_base     = int'(rd_ptr_q) * BYTE_W;

    if (clear) begin
      op_idx_d   = '0;
      byte_idx_d = '0;
      rd_ptr_d   = '0;
    end else if (act_load) begin
      operands_d[wr_base +: BYTE_W] = inputdata;
      dout_d = inputdata;
      if (last_byte) begin
        byte_idx_d = '0;
        op_idx_d   = last_op ? '0 : op_idx_q + OPI_W'(1);
      end else begin
        byte_idx_d = byte_idx_q + BI_W'(1);
      end
    end else if (act_rd) begin
      dout_d   = dataR[rd_base +: BYTE_W];
      rd_ptr_d = (rd_ptr_q == BI_W'(BYTES - 1)) ? '0 : rd_ptr_q + BI_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_idx_q    <= '0;
      byte_idx_q  <= '0;
      rd_ptr_q    <= '0;
      operands_q  <= '0;
      dout_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      op_idx_q    <= op_idx_d;
      byte_idx_q  <= byte_idx_d;
      rd_ptr_q    <= rd_ptr_d;
      operands_q  <= operands_d;
      dout_q      <= dout_d;
      load_done_q <= load_done_d;
    end
  end

endmodule

// File: tb/tb_peripheral_operand_loader.sv
// tb/tb_peripheral_operand_loader.sv - self-checking bench for peripheral_operand_loader
module tb_peripheral_operand_loader;

  localparam int BYTE_W  = 8;
  localparam int OP_W    = 32;
  localparam int NUM_OPS = 2;
  localparam int BYTES   = OP_W / BYTE_W;
  localparam int TOTAL   = NUM_OPS * BYTES;
`ifdef PERIPHERAL_OPERAND_LOADER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [BYTE_W-1:0]       inputdata;
  logic                    enterpulse;
  logic                    loaddata;
  logic                    clear;
  logic [OP_W-1:0]         dataR;
  logic [NUM_OPS*OP_W-1:0] operands;
  logic                    operands_valid;
  logic                    load_done;
  logic [BYTE_W-1:0]       dataoutput;
  logic [0:0]              op_idx;
  logic [1:0]              byte_idx;

  peripheral_operand_loader #(.BYTE_W(BYTE_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS)) dut (
    .clk            (clk),
    .reset          (reset),
    .inputdata      (inputdata),
    .enterpulse     (enterpulse),
    .loaddata       (loaddata),
    .clear          (clear),
    .dataR          (dataR),
    .operands       (operands),
    .operands_valid (operands_valid),
    .load_done      (load_done),
    .dataoutput     (dataoutput),
    .op_idx         (op_idx),
    .byte_idx       (byte_idx)
  );

  always #5 clk = ~clk;

  // Reference model: flat list of entered bytes, a write position within the set,
  // a full flag and a readback counter.
  logic [7:0] m_bytes [TOTAL];
  int         m_pos;
  bit         m_full;
  int         m_rd;
  logic [7:0] m_dout;
  bit         m_done;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_operands();
    logic [63:0] r = '0;
    for (int k = 0; k < TOTAL; k++) r |= 64'(m_bytes[k]) << (8 * k);
    return r;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < TOTAL; k++) m_bytes[k] = 8'h00;
    m_pos = 0; m_full = 0; m_rd = 0; m_dout = 8'h00; m_done = 0;
  endtask

  task automatic m_event(input bit ld, input logic [7:0] d, input logic [31:0] r, input bit clr);
    m_done = 0;
    if (clr) begin
      m_pos = 0; m_full = 0; m_rd = 0;
    end else if (ld) begin
      m_bytes[m_pos] = d;
      m_dout = d;
      m_pos++;
      m_full = 0;
      if (m_pos == TOTAL) begin
        m_pos = 0; m_full = 1; m_done = 1;
      end
    end else begin
      m_dout = r[8 * m_rd +: 8];
      m_rd = (m_rd + 1) % BYTES;
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".operands"}, operands, m_operands());
    check({ctx, ".valid"}, operands_valid, m_full);
    check({ctx, ".op_idx"}, op_idx, m_pos / BYTES);
    check({ctx, ".byte_idx"}, byte_idx, m_pos % BYTES);
    check({ctx, ".dataoutput"}, dataoutput, m_dout);
    check({ctx, ".load_done"}, load_done, m_done);
  endtask

  // One enter press; optional clear lands on the edge that would act on it.
  task automatic press(input bit ld, input logic [7:0] d, input logic [31:0] r, input bit clr);
    @(negedge clk);
    enterpulse = 1'b1; loaddata = ld; inputdata = d; dataR = r;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("pre.idx", {op_idx, byte_idx}, {1'((m_pos / BYTES)), 2'((m_pos % BYTES))});
    check("pre.dout", dataoutput, m_dout);
    clear = clr;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_event(ld, d, r, clr);
    check_all("act");
    @(negedge clk);
    enterpulse = 1'b0;
    @(negedge clk);
    m_done = 0;
    check("post.load_done", load_done, 1'b0);
  endtask

  task automatic load_set_test1();
    logic [7:0] seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) press(1'b1, seq[i], 32'h0, 1'b0);
    check("t1.operands", operands, 64'h8877665544332211);
    check("t1.valid", operands_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b1; enterpulse = 1'b0; loaddata = 1'b0; clear = 1'b0;
    inputdata = '0; dataR = '0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // 1: full set of eight bytes
    load_set_test1();

    // 2: held enter button gives a single event
    @(negedge clk);
    enterpulse = 1'b1; loaddata = 1'b1; inputdata = 8'hAB;
    repeat (20) @(negedge clk);
    enterpulse = 1'b0;
    m_event(1'b1, 8'hAB, 32'h0, 1'b0);
    m_done = 0;
    check_all("t2");
    check("t2.byte_idx", byte_idx, 2'd1);
    repeat (LAT + 2) @(negedge clk);

    // 3: readback walks the result bytes and wraps
    for (int i = 0; i < 5; i++) press(1'b0, 8'h00, 32'hDEADBEEF, 1'b0);
    check("t3.last", dataoutput, 8'hEF);

    // 4: mixed load/readback mid-set
    press(1'b1, 8'hA0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) press(1'b1, 8'(8'hC0 + i), 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) press(1'b0, 8'h00, 32'h01020304, 1'b0);
    for (int i = 3; i < 8; i++) press(1'b1, 8'(8'hC0 + i), 32'h0, 1'b0);
    check("t4.operands", operands, 64'hC7C6C5C4C3C2C1C0);

    // 5: clear collides with the fourth event
    for (int i = 0; i < 3; i++) press(1'b1, 8'(8'h30 + i), 32'h0, 1'b0);
    press(1'b1, 8'h3F, 32'h0, 1'b1);
    check("t5.byte_idx", byte_idx, 2'd0);
    press(1'b1, 8'h5A, 32'h0, 1'b0);
    check("t5.op0b0", operands[7:0], 8'h5A);

    // 6: asynchronous reset mid-set, then repeat the full set
    for (int i = 0; i < 5; i++) press(1'b1, 8'(8'h90 + i), 32'h0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    m_reset();
    check_all("t6.reset");
    @(negedge clk);
    reset = 1'b0;
    load_set_test1();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      press(($urandom % 3) != 0, 8'($urandom), $urandom, ($urandom % 12) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/peripheral_operand_loader.md
Name: peripheral_operand_loader

Overview:
Parametrised byte-serial operand entry and result readback peripheral for the switch/button front end.
- Each debounced-level "enter" press either stores the byte on the switches into the next operand slot (load mode) or presents the next byte of the result word on a byte output (readback mode).
- Generalises fixed two-operand, 32-bit entry to NUM_OPS operands of OP_W bits, with a proper state machine, completion strobe, clear and wrap handling.
- Sits between the board switch/button inputs and the arithmetic core.

Parameters:
BYTE_W, 8, width of one entered/displayed byte
OP_W, 32, operand and result width; must be an integer multiple of BYTE_W
NUM_OPS, 2, number of operands collected per set; must be ≥1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
inputdata  in  BYTE_W  switch byte to load
enterpulse  in  1  raw enter button level; rising edge is the event
loaddata  in  1  mode select: 1 = load, 0 = readback
clear  in  1  synchronous clear of load/readback progress
dataR  in  OP_W  result word from arithmetic core
operands  out  NUM_OPS*OP_W  operand k occupies bits [k*OP_W +: OP_W]
operands_valid  out  1  full operand set present
load_done  out  1  one-cycle strobe when last byte of last operand is written
dataoutput  out  BYTE_W  last loaded byte or current readback byte
op_idx  out  clog2(NUM_OPS) or 1 bit  next operand to be written
byte_idx  out  clog2(OP_W/BYTE_W) or 1 bit  next byte within operand

Behaviour:
Reset, asynchronous, immediate:
- All outputs 0 and all operand registers 0.
- State IDLE; read pointer 0; edge-detect flops 0.

Edge detection:
- Enter event = enterpulse sampled 1 on a clk edge after being 0 on the previous edge.
- The event acts on the next clk edge, giving one cycle of latency without the optional feature.
- Holding enterpulse high produces exactly one event.
- loaddata and inputdata are sampled on the same edge that acts on the event.

States:
- IDLE: no bytes loaded.
- LOAD: partial set.
- READY: full set.

Load event (loaddata = 1):
- Writes inputdata into operand op_idx, byte byte_idx. Byte 0 is least significant.
- Also updates dataoutput with inputdata.
- byte_idx increments. At BYTES−1 it wraps to 0 and op_idx increments.
- IDLE→LOAD on the first write.
- Writing byte BYTES−1 of operand NUM_OPS−1:
  - moves to READY;
  - operands_valid = 1;
  - load_done = 1 for exactly one cycle;
  - op_idx and byte_idx wrap to 0.
- Load event while in READY starts a new set:
  - writes operand 0 byte 0;
  - operands_valid → 0 on the same edge;
  - state → LOAD;
  - the other operand registers keep their stale values until overwritten.

Readback event (loaddata = 0):
- dataoutput ← dataR byte rd_ptr, then rd_ptr increments, wrapping from BYTES−1 to 0.
- Allowed in any state.
- Does not touch the load pointers, the state or the operands.
- Switching mode mid-load preserves load progress.

Clear:
- Returns to IDLE; op_idx, byte_idx, rd_ptr → 0; operands_valid → 0.
- Operand register contents and dataoutput are retained.
- Clear coincident with an enter event: clear wins and the event is discarded.

NUM_OPS = 1 or BYTES = 1:
- The corresponding index stays 0.
- Completion occurs on the appropriate single write.

Optional Feature:
Macro PERIPHERAL_OPERAND_LOADER_SYNC_EN.
- Defined: enterpulse and loaddata each pass through a two-flop synchroniser before edge detection. Event latency is 3 clk edges from the first sampling edge.
- Undefined: inputs go straight to the edge detector with 1-edge latency, as above.
- In both cases the synchroniser and edge flops reset to 0.

Decomposition:
Package peripheral_operand_pkg holds:
- typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} loader_state_t;
- localparam helper for BYTES = OP_W/BYTE_W, and index-width functions guarding the clog2(1) case.

Sub-module peripheral_edge_detect:
- Optional synchroniser plus rising-edge strobe.
- Reused for clear if it is ever button-driven.

Test Plan (default parameters):
1. Reset, then 8 load events with bytes 11,22,33,44,55,66,77,88 → operands = {0x88776655, 0x44332211}; operands_valid = 1 after the 8th event; load_done high exactly one cycle; indices back at 0.
2. enterpulse held high for 20 cycles in load mode with inputdata = 0xAB → only byte 0 of operand 0 is written; byte_idx = 1.
3. dataR = 0xDEADBEEF, 5 readback events → dataoutput sequence EF, BE, AD, DE, EF; load indices unchanged.
4. 3 load events, then 2 readback events, then 5 load events → set completes correctly with bytes in the proper slots; operands_valid rises only on the final load.
5. Clear asserted on the same cycle as the 4th event's action edge → byte not written; state IDLE; byte_idx = 0. A subsequent load writes operand 0 byte 0.
6. reset asserted mid-set (after 5 loads, asynchronously between edges) → all outputs 0 immediately. With the SYNC_EN macro defined, rerun test 1 and confirm 3-edge event latency.
